// File: rtl/bus_cycle_sequencer_pkg.sv
// Shared types for the PET bus cycle sequencer:
// slot identifiers, default slot lengths and address helpers.
package pet_bus_pkg;

    localparam int ADDR_WIDTH    = 17;
    localparam int VIDEO_LEN_DEF = 4;
    localparam int SPI_LEN_DEF   = 4;
    localparam int CPU_LEN_DEF   = 8;
    localparam int DEC_K         = 2;

    typedef enum logic [1:0] {
        SLOT_VIDEO = 2'd0,
        SLOT_SPI   = 2'd1,
        SLOT_CPU   = 2'd2
    } slot_t;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        logic active;
        logic wr;
    } acc_t;

    typedef struct packed {
        logic ram;
        logic io;
        logic ro;
    } sel_t;

    // 1KB of VRAM appears four times; fold the copies onto the first.
    function automatic addr_t mirror_fix(input addr_t a);
        addr_t r;
        r        = a;
        r[11:10] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/bus_cycle_sequencer_slot_counter.sv
// Bus cycle counter: tracks the cycle position and reports the
// current slot, slot-relative clock and slot/cycle boundaries.
module bus_slot_counter
    import pet_bus_pkg::*;
#(
    parameter int VIDEO_SLOT_LEN = VIDEO_LEN_DEF,
    parameter int SPI_SLOT_LEN   = SPI_LEN_DEF,
    parameter int CPU_SLOT_LEN   = CPU_LEN_DEF,
    parameter int CW = $clog2(VIDEO_SLOT_LEN + SPI_SLOT_LEN + CPU_SLOT_LEN)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    output slot_t         o_slot,
    output logic [CW-1:0] o_k,
    output logic          o_start,
    output logic          o_last,
    output logic          o_cyc_last
);

    localparam int N = VIDEO_SLOT_LEN + SPI_SLOT_LEN + CPU_SLOT_LEN;

    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(VIDEO_SLOT_LEN - 1);
    localparam logic [CW-1:0] S_LAST  = CW'(SPI_SLOT_LEN - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(CPU_SLOT_LEN - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_k;
    slot_t         r_slot;

    logic [CW-1:0] w_k_last;
    slot_t         w_slot_nxt;
    logic          w_last;
    logic          w_cyc_last;

    always_comb begin
        w_k_last   = C_LAST;
        w_slot_nxt = SLOT_VIDEO;
        unique case (1'b1)
            (r_slot == SLOT_VIDEO): begin
                w_k_last   = V_LAST;
                w_slot_nxt = SLOT_SPI;
            end
            (r_slot == SLOT_SPI): begin
                w_k_last   = S_LAST;
                w_slot_nxt = SLOT_CPU;
            end
            default: begin
                w_k_last   = C_LAST;
                w_slot_nxt = SLOT_VIDEO;
            end
        endcase
    end

    assign w_last     = (r_k == w_k_last);
    assign w_cyc_last = (r_cnt == CNT_MAX);

    // The cycle wrap also re-aligns slot state to VIDEO.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt  <= '0;
            r_k    <= '0;
            r_slot <= SLOT_VIDEO;
        end else if (w_cyc_last) begin
            r_cnt  <= '0;
            r_k    <= '0;
            r_slot <= SLOT_VIDEO;
        end else begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_k    <= '0;
                r_slot <= w_slot_nxt;
            end else begin
                r_k <= r_k + CW'(1);
            end
        end
    end

    assign o_slot     = r_slot;
    assign o_k        = r_k;
    assign o_start    = (r_k == '0);
    assign o_last     = w_last;
    assign o_cyc_last = w_cyc_last;

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Time-slices the 17-bit bus between video, SPI bridge and 6502 CPU.
// Define WRITE_PROTECT_EN to drop RAM writes into the ROM region.
module bus_cycle_sequencer
    import pet_bus_pkg::*;
#(
    parameter int VIDEO_SLOT_LEN = VIDEO_LEN_DEF,
    parameter int SPI_SLOT_LEN   = SPI_LEN_DEF,
    parameter int CPU_SLOT_LEN   = CPU_LEN_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    output logic        cpu_clk_en,
    input  logic        spi_req,
    input  logic [16:0] spi_addr,
    input  logic        spi_we,
    output logic        spi_ack,
    input  logic [16:0] video_addr,
    output logic        video_strobe,
    output logic [16:0] bus_addr,
    input  logic        ram_enable,
    input  logic        is_readonly,
    input  logic        is_mirrored,
    input  logic        io_enable,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic        io_strobe
);

    localparam int N  = VIDEO_SLOT_LEN + SPI_SLOT_LEN + CPU_SLOT_LEN;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] K_DEC = CW'(DEC_K);

`ifdef WRITE_PROTECT_EN
    localparam logic WP = 1'b1;
`else
    localparam logic WP = 1'b0;
`endif

    slot_t         w_slot;
    logic [CW-1:0] w_k;
    logic          w_start;
    logic          w_last;
    logic          w_cyc_last;

    bus_slot_counter #(
        .VIDEO_SLOT_LEN (VIDEO_SLOT_LEN),
        .SPI_SLOT_LEN   (SPI_SLOT_LEN),
        .CPU_SLOT_LEN   (CPU_SLOT_LEN),
        .CW             (CW)
    ) u_cnt (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .o_slot     (w_slot),
        .o_k        (w_k),
        .o_start    (w_start),
        .o_last     (w_last),
        .o_cyc_last (w_cyc_last)
    );

    addr_t r_bus_addr;
    acc_t  r_acc;
    sel_t  r_sel;
    logic  r_oe_n;
    logic  r_we_n;
    logic  r_io;
    logic  r_ack;
    logic  r_vs;
    logic  r_clk_en;

    addr_t w_src_addr;
    acc_t  w_src_acc;
    sel_t  w_sel;
    logic  w_dec;
    logic  w_client;
    logic  w_rd_win;
    logic  w_wr_win;
    logic  w_ram_acc;
    logic  w_rd_go;
    logic  w_wr_go;
    logic  w_io_go;

    // An idle SPI slot keeps the previous address on the bus.
    always_comb begin
        w_src_addr = r_bus_addr;
        w_src_acc  = acc_t'{active: 1'b1, wr: 1'b0};
        unique case (1'b1)
            (w_slot == SLOT_VIDEO): begin
                w_src_addr = video_addr;
            end
            (w_slot == SLOT_SPI): begin
                w_src_acc = acc_t'{active: spi_req, wr: spi_we};
                if (spi_req) begin
                    w_src_addr = spi_addr;
                end
            end
            default: begin
                w_src_addr = {1'b0, cpu_addr};
                w_src_acc  = acc_t'{active: 1'b1, wr: ~cpu_rw};
            end
        endcase
    end

    // Decoder selects are live at k=2 and held for the slot remainder.
    assign w_dec = (w_k == K_DEC);
    assign w_sel = w_dec ? sel_t'{ram: ram_enable,
                                  io:  io_enable,
                                  ro:  is_readonly}
                         : r_sel;

    assign w_client  = (w_slot != SLOT_VIDEO);
    assign w_rd_win  = (w_k >= K_DEC);
    assign w_wr_win  = w_rd_win & ~w_last;
    assign w_ram_acc = r_acc.active & w_sel.ram & ~w_sel.io;

    assign w_rd_go = w_ram_acc & ~r_acc.wr & w_rd_win;
    assign w_wr_go = w_ram_acc & r_acc.wr & w_client
                   & w_wr_win & ~(WP & w_sel.ro);
    assign w_io_go = w_dec & r_acc.active & w_client & io_enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_addr <= '0;
            r_acc      <= '0;
            r_sel      <= '0;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_io       <= 1'b0;
            r_ack      <= 1'b0;
            r_vs       <= 1'b0;
            r_clk_en   <= 1'b0;
        end else begin
            if (w_start) begin
                r_bus_addr <= w_src_addr;
                r_acc      <= w_src_acc;
            end else if (w_dec && r_acc.active && is_mirrored) begin
                r_bus_addr <= mirror_fix(r_bus_addr);
            end
            if (w_dec) begin
                r_sel <= w_sel;
            end
            r_oe_n   <= ~w_rd_go;
            r_we_n   <= ~w_wr_go;
            r_io     <= w_io_go;
            r_ack    <= (w_slot == SLOT_SPI) & w_last & r_acc.active;
            r_vs     <= (w_slot == SLOT_VIDEO) & w_last;
            r_clk_en <= w_cyc_last;
        end
    end

    assign bus_addr     = r_bus_addr;
    assign ram_oe_n     = r_oe_n;
    assign ram_we_n     = r_we_n;
    assign io_strobe    = r_io;
    assign spi_ack      = r_ack;
    assign video_strobe = r_vs;
    assign cpu_clk_en   = r_clk_en;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench for bus_cycle_sequencer: directed slot table,
// reset cases and randomized cycles against a slot-level model.
module tb_bus_cycle_sequencer;

    localparam int V = 4;
    localparam int S = 4;
    localparam int C = 8;
    localparam int N = V + S + C;

    localparam logic [16:0] V_ADDR = 17'h15A5C;

`ifdef WRITE_PROTECT_EN
    localparam logic        WP      = 1'b1;
    localparam logic [7:0]  WE_S_RO = 8'h00;
    localparam logic [7:0]  WE_C_RO = 8'h00;
`else
    localparam logic        WP      = 1'b0;
    localparam logic [7:0]  WE_S_RO = 8'h04;
    localparam logic [7:0]  WE_C_RO = 8'h7C;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rw = 1'b1;
    logic        cpu_clk_en;
    logic        spi_req = 1'b0;
    logic [16:0] spi_addr = '0;
    logic        spi_we = 1'b0;
    logic        spi_ack;
    logic [16:0] video_addr = V_ADDR;
    logic        video_strobe;
    logic [16:0] bus_addr;
    logic        ram_enable = 1'b0;
    logic        is_readonly = 1'b0;
    logic        is_mirrored = 1'b0;
    logic        io_enable = 1'b0;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        io_strobe;

    bus_cycle_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_addr     (cpu_addr),
        .cpu_rw       (cpu_rw),
        .cpu_clk_en   (cpu_clk_en),
        .spi_req      (spi_req),
        .spi_addr     (spi_addr),
        .spi_we       (spi_we),
        .spi_ack      (spi_ack),
        .video_addr   (video_addr),
        .video_strobe (video_strobe),
        .bus_addr     (bus_addr),
        .ram_enable   (ram_enable),
        .is_readonly  (is_readonly),
        .is_mirrored  (is_mirrored),
        .io_enable    (io_enable),
        .ram_oe_n     (ram_oe_n),
        .ram_we_n     (ram_we_n),
        .io_strobe    (io_strobe)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cnt = 0;

    typedef struct {
        int          slot;
        logic [16:0] addr;
        logic        wr;
        logic        req;
        logic        ram;
        logic        io;
        logic        ro;
        logic        mir;
        logic [16:0] a0;
        logic [16:0] a2;
        logic [7:0]  oe_m;
        logic [7:0]  we_m;
        logic [7:0]  io_m;
    } vec_t;

    localparam int NV = 10;
    vec_t vt[NV];

    task automatic chk1(string nm, logic got, logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic chka(string nm, logic [16:0] got, logic [16:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One clock: c is the cycle position the DUT registered on this edge.
    task automatic tick(output int c);
        @(posedge clk);
        c = cnt;
        cnt = (cnt + 1) % N;
        @(negedge clk);
    endtask

    function automatic int slot_base(int s);
        return (s == 0) ? 0 : (s == 1) ? V : V + S;
    endfunction

    function automatic int slot_len(int s);
        return (s == 0) ? V : (s == 1) ? S : C;
    endfunction

    task automatic idle_inputs();
        spi_req     = 1'b0;
        spi_we      = 1'b0;
        cpu_rw      = 1'b1;
        video_addr  = V_ADDR;
        ram_enable  = 1'b0;
        io_enable   = 1'b0;
        is_readonly = 1'b0;
        is_mirrored = 1'b0;
    endtask

    task automatic run_vec(int i);
        vec_t v;
        int   c;
        int   len;
        string p;
        v   = vt[i];
        len = slot_len(v.slot);
        while (cnt != slot_base(v.slot)) tick(c);
        idle_inputs();
        case (v.slot)
            0: video_addr = v.addr;
            1: begin
                spi_req  = v.req;
                spi_addr = v.addr;
                spi_we   = v.wr;
            end
            default: begin
                cpu_addr = v.addr[15:0];
                cpu_rw   = ~v.wr;
            end
        endcase
        ram_enable  = v.ram;
        io_enable   = v.io;
        is_readonly = v.ro;
        is_mirrored = v.mir;
        for (int k = 0; k < len; k++) begin
            tick(c);
            if (v.slot == 1 && k == 1) spi_req = 1'b0;
            p = $sformatf("v%0d k%0d", i, k);
            chka({p, " addr"}, bus_addr, (k < 2) ? v.a0 : v.a2);
            chk1({p, " oe_n"}, ram_oe_n, ~v.oe_m[k]);
            chk1({p, " we_n"}, ram_we_n, ~v.we_m[k]);
            chk1({p, " io"}, io_strobe, v.io_m[k]);
            chk1({p, " ack"}, spi_ack,
                 v.slot == 1 && v.req && k == len - 1);
            chk1({p, " vs"}, video_strobe,
                 v.slot == 0 && k == len - 1);
            chk1({p, " clken"}, cpu_clk_en,
                 v.slot == 2 && k == len - 1);
        end
        idle_inputs();
    endtask

    // Slot-level reference: what a whole slot should do from its
    // sampled request, decoder selects and position within the slot.
    typedef struct {
        bit          act;
        bit          wr;
        bit          ram;
        bit          io;
        bit          ro;
        bit          mir;
        logic [16:0] src;
    } mslot_t;

    task automatic run_random(int cycles);
        mslot_t      m;
        logic [16:0] m_addr;
        int          c;
        int          len;
        bit          acc;
        string       p;
        m_addr = '0;
        while (cnt != 0) tick(c);
        for (int cy = 0; cy < cycles; cy++) begin
            for (int s = 0; s < 3; s++) begin
                video_addr  = 17'($urandom);
                spi_addr    = 17'($urandom);
                cpu_addr    = 16'($urandom);
                spi_we      = 1'($urandom_range(0, 1));
                cpu_rw      = 1'($urandom_range(0, 1));
                spi_req     = ($urandom_range(0, 3) != 0);
                ram_enable  = ($urandom_range(0, 3) != 0);
                io_enable   = ($urandom_range(0, 3) == 0);
                is_readonly = 1'($urandom_range(0, 1));
                is_mirrored = 1'($urandom_range(0, 1));
                m.act = (s != 1) || spi_req;
                m.wr  = (s == 2) ? !cpu_rw : (s == 1) ? spi_we : 1'b0;
                m.ram = ram_enable;
                m.io  = io_enable;
                m.ro  = is_readonly;
                m.mir = is_mirrored;
                m.src = (s == 0) ? video_addr :
                        (s == 1) ? spi_addr : {1'b0, cpu_addr};
                len = slot_len(s);
                for (int k = 0; k < len; k++) begin
                    tick(c);
                    if (k == 1 && $urandom_range(0, 1) == 1)
                        spi_req = ~spi_req;
                    if (k == 0 && m.act) m_addr = m.src;
                    if (k == 2 && m.act && m.mir) m_addr[11:10] = 2'b00;
                    acc = m.act && m.ram && !m.io;
                    p = $sformatf("rnd c%0d s%0d k%0d", cy, s, k);
                    chka({p, " addr"}, bus_addr, m_addr);
                    chk1({p, " oe_n"}, ram_oe_n,
                         !(acc && !m.wr && k >= 2));
                    chk1({p, " we_n"}, ram_we_n,
                         !(acc && m.wr && s != 0 && k >= 2 &&
                           k <= len - 2 && !(WP && m.ro)));
                    chk1({p, " io"}, io_strobe,
                         m.act && m.io && s != 0 && k == 2);
                    chk1({p, " ack"}, spi_ack,
                         s == 1 && m.act && k == len - 1);
                    chk1({p, " vs"}, video_strobe, s == 0 && k == len - 1);
                    chk1({p, " clken"}, cpu_clk_en, c == N - 1);
                    chk1({p, " excl"}, ram_oe_n | ram_we_n, 1'b1);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;

        vt[0] = '{2, 17'h08400, 0, 1, 1, 0, 0, 1,
                  17'h08400, 17'h08000, 8'hFC, 8'h00, 8'h00};
        vt[1] = '{2, 17'h01234, 1, 1, 1, 0, 0, 0,
                  17'h01234, 17'h01234, 8'h00, 8'h7C, 8'h00};
        vt[2] = '{1, 17'h1F000, 1, 1, 1, 0, 1, 0,
                  17'h1F000, 17'h1F000, 8'h00, WE_S_RO, 8'h00};
        vt[3] = '{2, 17'h0E810, 0, 1, 0, 1, 0, 0,
                  17'h0E810, 17'h0E810, 8'h00, 8'h00, 8'h04};
        vt[4] = '{1, 17'h00C55, 0, 1, 1, 0, 0, 1,
                  17'h00C55, 17'h00055, 8'h0C, 8'h00, 8'h00};
        vt[5] = '{1, 17'h1FFFF, 1, 0, 1, 1, 0, 1,
                  V_ADDR, V_ADDR, 8'h00, 8'h00, 8'h00};
        vt[6] = '{1, 17'h0E820, 1, 1, 1, 1, 0, 0,
                  17'h0E820, 17'h0E820, 8'h00, 8'h00, 8'h04};
        vt[7] = '{2, 17'h0C000, 1, 1, 1, 0, 1, 0,
                  17'h0C000, 17'h0C000, 8'h00, WE_C_RO, 8'h00};
        vt[8] = '{0, 17'h10C00, 0, 1, 1, 0, 0, 1,
                  17'h10C00, 17'h10000, 8'h0C, 8'h00, 8'h00};
        vt[9] = '{2, 17'h0A7FF, 1, 1, 1, 0, 0, 1,
                  17'h0A7FF, 17'h0A3FF, 8'h00, 8'h7C, 8'h00};

        idle_inputs();
        repeat (3) @(negedge clk);
        chka("rst addr", bus_addr, 17'h0);
        chk1("rst oe_n", ram_oe_n, 1'b1);
        chk1("rst we_n", ram_we_n, 1'b1);
        chk1("rst io", io_strobe, 1'b0);
        chk1("rst clken", cpu_clk_en, 1'b0);
        chk1("rst ack", spi_ack, 1'b0);
        chk1("rst vs", video_strobe, 1'b0);
        reset_n = 1'b1;
        cnt = 0;

        for (int t = 0; t < 3 * N; t++) begin
            tick(c);
            chk1($sformatf("free t%0d clken", t), cpu_clk_en,
                 (t % N) == N - 1);
            chk1($sformatf("free t%0d vs", t), video_strobe,
                 (t % N) == V - 1);
            chk1($sformatf("free t%0d ack", t), spi_ack, 1'b0);
        end

        for (int i = 0; i < NV; i++) run_vec(i);

        while (cnt != V + S) tick(c);
        cpu_addr   = 16'h1234;
        cpu_rw     = 1'b0;
        ram_enable = 1'b1;
        for (int k = 0; k <= 4; k++) tick(c);
        chk1("midrst pre we_n", ram_we_n, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk1("midrst we_n", ram_we_n, 1'b1);
        chk1("midrst oe_n", ram_oe_n, 1'b1);
        chka("midrst addr", bus_addr, 17'h0);
        chk1("midrst clken", cpu_clk_en, 1'b0);
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        cnt = 0;
        tick(c);
        chka("release addr", bus_addr, V_ADDR);
        for (int t = 1; t < N; t++) begin
            tick(c);
            chk1($sformatf("release t%0d vs", t), video_strobe, t == V - 1);
            chk1($sformatf("release t%0d clken", t), cpu_clk_en, t == N - 1);
        end

        run_random(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
